shiftadd_seq_ctrl: RTL and testbench

Sequencing controller for the 64-bit, 3-chunk shift-add modular reducer (shiftadd_parallel).
- Accepts a modulus configuration and finds its bit length with a multi-cycle MSB scan.
- Classifies the modulus as Mersenne, Fermat or unsupported.
- Streams operands through the reducer in a 2-stage valid/ready pipeline, rejecting operands the 3-chunk fold cannot reduce.
- Sits between the operand source (testbench or host) and the reducer instance.

---
 rtl/shiftadd_pkg.sv | 29 ++
 rtl/shiftadd_parallel.sv | 40 ++++
 rtl/shiftadd_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_shiftadd_seq_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftadd_pkg.sv
// Shared types and constants for the shift-add modular reduction slice.
// The controller and the 3-chunk reducer both import this package.
package shiftadd_pkg;

  localparam int DATA_LENGTH = 64;
  localparam int NUM_CHUNKS  = 3;

  typedef enum logic [1:0] {
    MK_NONE     = 2'd0,
    MK_MERSENNE = 2'd1,
    MK_FERMAT   = 2'd2,
    MK_UNSUP    = 2'd3
  } mod_kind_e;

  typedef enum logic [1:0] {
    S_UNCFG,
    S_SCAN,
    S_CLASSIFY,
    S_READY
  } ctrl_state_e;

  // 2^n - 1 as a DATA_LENGTH-bit value; n = DATA_LENGTH gives all ones.
  function automatic logic [DATA_LENGTH-1:0] low_mask(input logic [7:0] n);
    logic [DATA_LENGTH:0] one_n;
    one_n = (DATA_LENGTH+1)'(1) << n;
    return DATA_LENGTH'(one_n - (DATA_LENGTH+1)'(1));
  endfunction

endpackage

// File: rtl/shiftadd_parallel.sv
// Combinational 3-chunk shift-add reducer for m = 2^k-1 or m = 2^k+1.
// Valid only for x < 2^(3k); the controller masks anything else.
module shiftadd_parallel
  import shiftadd_pkg::*;
(
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [7:0]             m_bl_i,
  output logic [DATA_LENGTH-1:0] r_o
);

  logic                   is_mersenne;
  logic [7:0]             k;
  logic [8:0]             k2;
  logic [DATA_LENGTH-1:0] mask;
  logic [DATA_LENGTH-1:0] c0, c1, c2;
  logic [DATA_LENGTH+2:0] m_ext, m2, t;

  // NOTE: every variable gets a value on every path through always_comb,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    is_mersenne = (m_i == low_mask(m_bl_i));
    k           = is_mersenne ? m_bl_i : m_bl_i - 8'd1;
    k2          = {k, 1'b0};
    mask        = low_mask(k);
    c0          = x_i & mask;
    c1          = (x_i >> k) & mask;
    c2          = (x_i >> k2) & mask;
    m_ext       = {3'b000, m_i};
    m2          = {m_ext[DATA_LENGTH+1:0], 1'b0};
    // 2^k == 1 (Mersenne) or -1 (Fermat); adding m keeps the Fermat sum positive.
    if (is_mersenne) t = {3'b000, c0} + {3'b000, c1} + {3'b000, c2};
    else             t = {3'b000, c0} + {3'b000, c2} + m_ext - {3'b000, c1};
    // Both folds land below or at 3m, so two conditional subtractions suffice.
    if (t >= m2)    t = t - m2;
    if (t >= m_ext) t = t - m_ext;
    r_o = t[DATA_LENGTH-1:0];
  end

endmodule

// File: rtl/shiftadd_seq_ctrl.sv
// Sequencing controller: scans and classifies the modulus, then streams
// operands through the reducer in a 2-stage valid/ready pipeline.
module shiftadd_seq_ctrl
  import shiftadd_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [DATA_LENGTH-1:0] cfg_mod_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_LENGTH-1:0] in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_LENGTH-1:0] out_data_o,
  output logic                   out_err_o,
  output logic [1:0]             mod_kind_o,
  output logic                   busy_o
);

  ctrl_state_e            state, state_n;
  logic [DATA_LENGTH-1:0] m_q;
  logic [5:0]             idx_q;
  logic [6:0]             bl_q, k_q;
  mod_kind_e              kind_q;

  logic                   s1_valid, s1_err;
  logic [DATA_LENGTH-1:0] s1_x, red_data;

  logic       advance, cfg_hs, in_hs, in_err, is_mers, is_ferm;
  logic [7:0] shamt;

  assign advance    = !out_valid_o || out_ready_i;
  assign in_ready_o = (state == S_READY) && advance;
  // An operand offered alongside a config in an empty READY wins; the config
  // waits until that operand has drained.
  assign cfg_ready_o = ((state == S_UNCFG) || (state == S_READY && !in_valid_i))
                       && !s1_valid && !out_valid_o;
  assign cfg_hs     = cfg_valid_i && cfg_ready_o;
  assign in_hs      = in_valid_i && in_ready_o;
  assign busy_o     = (state == S_SCAN) || (state == S_CLASSIFY) || s1_valid || out_valid_o;
  assign mod_kind_o = kind_q;

  assign is_mers = (bl_q >= 7'd2) && (m_q == low_mask({1'b0, bl_q}));
  assign is_ferm = (bl_q >= 7'd3) && (m_q == ((DATA_LENGTH'(1) << (bl_q - 7'd1)) + DATA_LENGTH'(1)));

  assign shamt  = 8'(NUM_CHUNKS) * {1'b0, k_q};
  assign in_err = (kind_q == MK_UNSUP) || ((shamt < 8'd64) && ((in_data_i >> shamt) != '0));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_UNCFG;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_UNCFG:    if (cfg_hs) state_n = S_SCAN;
      S_SCAN:     if (m_q[idx_q] || idx_q == 6'd0) state_n = S_CLASSIFY;
      S_CLASSIFY: state_n = S_READY;
      S_READY:    if (cfg_hs) state_n = S_SCAN;
      default:    state_n = S_UNCFG;
    endcase
  end

  // Modulus scanner and classifier; mod_kind_o keeps the old kind until CLASSIFY.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_q    <= '0;
      idx_q  <= '0;
      bl_q   <= '0;
      k_q    <= '0;
      kind_q <= MK_NONE;
    end else if (cfg_hs) begin
      m_q   <= cfg_mod_i;
      idx_q <= 6'd63;
    end else if (state == S_SCAN) begin
      if (m_q[idx_q])          bl_q  <= {1'b0, idx_q} + 7'd1;
      else if (idx_q == 6'd0)  bl_q  <= '0;
      else                     idx_q <= idx_q - 6'd1;
    end else if (state == S_CLASSIFY) begin
      if (is_mers) begin
        kind_q <= MK_MERSENNE;
        k_q    <= bl_q;
      end else if (is_ferm) begin
        kind_q <= MK_FERMAT;
        k_q    <= bl_q - 7'd1;
      end else begin
        kind_q <= MK_UNSUP;
        k_q    <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_err_o   <= 1'b0;
    end else if (advance) begin
      s1_valid    <= in_hs;
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        out_data_o <= s1_err ? '0 : red_data;
        out_err_o  <= s1_err;
      end
    end
  end

  // NOTE: stage-1 payload has no reset; s1_valid qualifies it, so clearing
  // the data would only cost reset routing.
  always_ff @(posedge clk_i) begin
    if (in_hs) begin
      s1_x   <= in_data_i;
      s1_err <= in_err;
    end
  end

  shiftadd_parallel u_reducer (
    .x_i    (s1_x),
    .m_i    (m_q),
    .m_bl_i ({1'b0, bl_q}),
    .r_o    (red_data)
  );

endmodule

// File: tb/tb_shiftadd_seq_ctrl.sv
// Self-checking bench for shiftadd_seq_ctrl: directed steps plus randomized
// streams scored against an arithmetic reference model (%, $clog2, shifts).
module tb_shiftadd_seq_ctrl;
  import shiftadd_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, cfg_valid_i, in_valid_i, out_ready_i;
  logic [63:0] cfg_mod_i, in_data_i;
  logic        cfg_ready_o, in_ready_o, out_valid_o, out_err_o, busy_o;
  logic [63:0] out_data_o;
  logic [1:0]  mod_kind_o;

  always #5 clk_i = ~clk_i;

  shiftadd_seq_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_mod_i(cfg_mod_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_err_o(out_err_o),
    .mod_kind_o(mod_kind_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic [63:0] cur_m;
  int          cur_bl, cur_k, cur_kind;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: bit length, kind and k straight from the modulus value.
  task automatic model_cfg(input logic [63:0] m);
    logic [64:0] mp1, p;
    mp1    = {1'b0, m} + 65'd1;
    cur_m  = m;
    cur_bl = $clog2(mp1);
    p      = 65'd1 << cur_bl;
    if (cur_bl >= 2 && {1'b0, m} == p - 65'd1) begin
      cur_kind = 1; cur_k = cur_bl;
    end else if (cur_bl >= 3 && {1'b0, m} == (p >> 1) + 65'd1) begin
      cur_kind = 2; cur_k = cur_bl - 1;
    end else begin
      cur_kind = 3; cur_k = 0;
    end
  endtask

  function automatic exp_t model_op(input logic [63:0] x);
    exp_t e;
    int   sh;
    sh    = 3 * cur_k;
    e.err = (cur_kind == 3) || (sh < 64 && (x >> sh) != 64'd0);
    e.data = e.err ? 64'd0 : x % cur_m;
    return e;
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] r;
    logic [64:0] lim;
    int          sel, sh;
    r   = {$urandom(), $urandom()};
    sh  = 3 * cur_k;
    sel = int'($urandom_range(9));
    if (sh >= 64 || cur_kind == 3) return r;
    lim = 65'd1 << sh;
    if (sel == 9) return lim[63:0] - 64'd1;
    if (sel == 8) return lim[63:0];
    if (sel < 7)  return r & (lim[63:0] - 64'd1);
    return r;
  endfunction

  task automatic check_reset_values(input string pfx);
    check({pfx, "_cfg_ready"}, cfg_ready_o, 1);
    check({pfx, "_in_ready"},  in_ready_o,  0);
    check({pfx, "_out_valid"}, out_valid_o, 0);
    check({pfx, "_out_data"},  out_data_o,  0);
    check({pfx, "_out_err"},   out_err_o,   0);
    check({pfx, "_mod_kind"},  mod_kind_o,  0);
    check({pfx, "_busy"},      busy_o,      0);
  endtask

  // Offer a modulus, then measure edges from handshake until the pipe opens.
  task automatic configure(input logic [63:0] m);
    int n, lat;
    model_cfg(m);
    in_valid_i  = 1'b0;
    cfg_mod_i   = m;
    cfg_valid_i = 1'b1;
    #1;
    n = 0;
    while (!cfg_ready_o && n < 200) begin
      @(posedge clk_i); #1; n++;
    end
    check("cfg_ready_wait", cfg_ready_o, 1);
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0;
    check("busy_in_scan", busy_o, 1);
    n = 0;
    while (!in_ready_o && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    lat = (cur_bl == 0) ? 64 : 65 - cur_bl;
    check("scan_latency", n, lat + 1);
    check("mod_kind", mod_kind_o, cur_kind);
  endtask

  task automatic single_op(input logic [63:0] x);
    exp_t e;
    int   n;
    e           = model_op(x);
    out_ready_i = 1'b1;
    in_data_i   = x;
    in_valid_i  = 1'b1;
    #1;
    n = 0;
    while (!in_ready_o && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    check("op_in_ready", in_ready_o, 1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    check("op_lat_not_yet", out_valid_o, 0);
    @(posedge clk_i); #1;
    check("op_valid", out_valid_o, 1);
    check("op_data", out_data_o, e.data);
    check("op_err", out_err_o, e.err);
    @(posedge clk_i); #1;
    check("op_consumed", out_valid_o, 0);
  endtask

  // Random valid/ready traffic, scored in order against the model queue.
  task automatic stream(input int n_ops, input int p_valid, input int p_ready);
    int          sent, cyc;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_err;
    exp_t        e;
    sent = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_err = 1'b0;
    while ((sent < n_ops || sb.size() > 0) && cyc < 3000) begin
      in_valid_i  = (sent < n_ops) && (int'($urandom_range(99)) < p_valid);
      in_data_i   = rand_operand();
      out_ready_i = int'($urandom_range(99)) < p_ready;
      #1;
      if (out_valid_o && !out_ready_i) check("stall_in_ready", in_ready_o, 0);
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) check("spurious_out", out_valid_o, 0);
        else begin
          e = sb.pop_front();
          check("stream_data", out_data_o, e.data);
          check("stream_err", out_err_o, e.err);
        end
      end
      if (in_valid_i && in_ready_o) begin
        sb.push_back(model_op(in_data_i));
        sent++;
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
      prev_err   = out_err_o;
      @(posedge clk_i); #1;
      if (prev_stall) begin
        check("stall_valid", out_valid_o, 1);
        check("stall_data", out_data_o, prev_data);
        check("stall_err", out_err_o, prev_err);
      end
      cyc++;
    end
    check("stream_drained", sb.size(), 0);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic expect_idle_after_reset(input string tag);
    logic stale;
    stale = 1'b0;
    repeat (70) begin
      @(posedge clk_i); #1;
      if (out_valid_o || busy_o || in_ready_o || mod_kind_o != 2'd0) stale = 1'b1;
    end
    check(tag, stale, 0);
  endtask

  initial begin
    logic [63:0] hold;
    rst_i = 1'b1; cfg_valid_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    cfg_mod_i = '0; in_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_values("reset");
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Mersenne 7: single ops, back-to-back burst, stall, simultaneous cfg.
    configure(64'd7);
    single_op(64'd100);
    single_op(64'd600);
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_data_i = 64'd6;
    @(posedge clk_i); #1;
    in_data_i = 64'd7;
    @(posedge clk_i); #1;
    check("b2b_0_valid", out_valid_o, 1);
    check("b2b_0_data", out_data_o, 6);
    in_data_i = 64'd8;
    @(posedge clk_i); #1;
    check("b2b_1_data", out_data_o, 0);
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("b2b_2_valid", out_valid_o, 1);
    check("b2b_2_data", out_data_o, 1);
    @(posedge clk_i); #1;
    check("b2b_empty", out_valid_o, 0);

    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 64'd13;
    @(posedge clk_i); #1;
    in_data_i = 64'd20;
    @(posedge clk_i); #1;
    in_data_i = 64'd50;
    hold = out_data_o;
    check("stall_first", hold, 13 % 7);
    repeat (5) begin
      @(posedge clk_i); #1;
      check("stall5_in_ready", in_ready_o, 0);
      check("stall5_data", out_data_o, hold);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("drain_second", out_data_o, 20 % 7);
    check("drain_second_v", out_valid_o, 1);
    @(posedge clk_i); #1;
    check("drain_done", out_valid_o, 0);

    cfg_mod_i = 64'd17; cfg_valid_i = 1'b1;
    in_data_i = 64'd9;  in_valid_i = 1'b1;
    #1;
    check("simul_cfg_ready", cfg_ready_o, 0);
    check("simul_in_ready", in_ready_o, 1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("simul_old_mod", out_data_o, 9 % 7);
    check("simul_kind_kept", mod_kind_o, 1);

    // Fermat 17, then a handful of other moduli with random streams.
    configure(64'd17);
    single_op(64'd200);
    single_op(64'd4096);
    stream(40, 80, 60);
    configure(64'd10);
    single_op(64'd5);
    stream(10, 90, 90);
    configure(64'd0);
    configure(64'd1);
    configure(64'd3);
    stream(30, 90, 70);
    configure(64'd5);
    stream(30, 70, 50);
    configure(64'd65537);
    stream(30, 90, 80);
    configure(64'h1FFF_FFFF_FFFF_FFFF);
    stream(30, 90, 60);
    configure(64'h0000_0001_0000_0001);
    stream(30, 80, 70);
    configure(64'hFFFF_FFFF_FFFF_FFFF);
    stream(30, 100, 100);

    // Reset in the middle of a scan.
    cfg_mod_i = 64'd17; cfg_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_reset_values("rst_scan");
    rst_i = 1'b0;
    expect_idle_after_reset("rst_scan_no_stale");

    // Reset with both pipeline stages full.
    configure(64'd7);
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 64'd3;
    @(posedge clk_i); #1;
    in_data_i = 64'd4;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    check("full_pipe_valid", out_valid_o, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_reset_values("rst_pipe");
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    expect_idle_after_reset("rst_pipe_no_stale");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
